sram_port_arbiter: RTL

Shares the core's single SRAM-like memory port between the instruction-fetch master and the Memory-stage data master. Grants one transaction at a time with data priority and an inst anti-starvation counter. Holds the granted request stable on the slave port until accepted, and routes the response back to its owner. Discards instruction responses cancelled by a pipeline flush. Sits between the fetch and Memory stages and the AXI bridge inside mycpu_core.

---
 rtl/sram_port_arbiter_pkg.sv | 6 +
 rtl/sram_port_arbiter.sv | 96 +++++++++
 2 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg: state/owner encodings and default starvation limit for the memory port arbiter
package sram_port_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_REQ = 2'd1, ARB_WAIT = 2'd2} arb_state_e;
  typedef enum logic {ARB_OWN_INST = 1'b0, ARB_OWN_DATA = 1'b1} arb_own_e;
  localparam int ARB_STARVE_LIMIT = 4;
endpackage

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM-like port between fetch and data masters, one transaction at a time
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  arb_state_e    state_q;
  arb_own_e      own_q;
  logic          wr_q, discard_q;
  logic [1:0]    size_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   addr_q, wdata_q;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          idle, inst_go, data_go, inst_forced;
  assign idle        = state_q == ARB_IDLE;
  assign inst_forced = inst_req && !flush && starve_cnt_q == LIM;
  // rst gates the grants so every output reads 0 while reset is held
  assign inst_go     = rst && idle && inst_req && !flush && (inst_forced || !data_req);
  assign data_go     = rst && idle && data_req && !inst_forced;
  assign starve_cnt_d = (inst_go || !inst_req) ? '0 :
                        (starve_cnt_q == LIM ? starve_cnt_q : starve_cnt_q + 1'b1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      own_q        <= ARB_OWN_INST;
      wr_q         <= 1'b0;
      size_q       <= '0;
      wstrb_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      discard_q    <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      if (inst_go || data_go) begin
        state_q      <= ARB_REQ;
        own_q        <= data_go ? ARB_OWN_DATA : ARB_OWN_INST;
        wr_q         <= data_go && data_wr;
        size_q       <= data_go ? data_size : 2'd2;
        wstrb_q      <= data_go ? data_wstrb : 4'd0;
        addr_q       <= data_go ? data_addr : inst_addr;
        wdata_q      <= data_go ? data_wdata : 32'd0;
        discard_q    <= 1'b0;
        starve_cnt_q <= starve_cnt_d;
      end else if (state_q == ARB_REQ && mem_addr_ok) begin
        state_q <= ARB_WAIT;
      end else if (state_q == ARB_WAIT && mem_data_ok) begin
        state_q <= ARB_IDLE;
      end
      if (!idle && own_q == ARB_OWN_INST && flush) discard_q <= 1'b1;
    end
  end
  assign inst_addr_ok = inst_go;
  assign data_addr_ok = data_go;
  assign mem_req      = state_q == ARB_REQ;
  assign mem_wr       = wr_q;
  assign mem_size     = size_q;
  assign mem_wstrb    = wstrb_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign busy         = !idle;
  // a flush in the completion cycle also suppresses the inst response
  assign inst_data_ok = state_q == ARB_WAIT && mem_data_ok && own_q == ARB_OWN_INST && !discard_q && !flush;
  assign data_data_ok = state_q == ARB_WAIT && mem_data_ok && own_q == ARB_OWN_DATA;
  assign inst_rdata   = inst_data_ok ? mem_rdata : 32'd0;
  assign data_rdata   = data_data_ok ? mem_rdata : 32'd0;
endmodule
